// File: rtl/borsa_emir_sirala_if.sv
// Quote-bundle, decision and balance signals of the order scheduler.
// The slave modport is the scheduler's view; the master modport is the driver's view.
interface borsa_emir_sirala_if;
  logic        bakiye_yukle;
  logic [63:0] bakiye_giris;
  logic        teklif_gecerli;
  logic        teklif_hazir;
  logic [9:0]  hisse_numarasi1;
  logic [31:0] hisse_deger1;
  logic [9:0]  hisse_numarasi2;
  logic [31:0] hisse_deger2;
  logic [9:0]  hisse_numarasi3;
  logic [31:0] hisse_deger3;
  logic        karar_gecerli;
  logic        karar_hazir;
  logic [9:0]  karar_no;
  logic [1:0]  karar;
  logic [63:0] kagit_sayisi;
  logic [63:0] bakiye;
  logic        mesgul;

  modport slave (
    input  bakiye_yukle, bakiye_giris, teklif_gecerli,
    input  hisse_numarasi1, hisse_deger1, hisse_numarasi2, hisse_deger2,
    input  hisse_numarasi3, hisse_deger3, karar_hazir,
    output teklif_hazir, karar_gecerli, karar_no, karar, kagit_sayisi, bakiye, mesgul
  );

  modport master (
    output bakiye_yukle, bakiye_giris, teklif_gecerli,
    output hisse_numarasi1, hisse_deger1, hisse_numarasi2, hisse_deger2,
    output hisse_numarasi3, hisse_deger3, karar_hazir,
    input  teklif_hazir, karar_gecerli, karar_no, karar, kagit_sayisi, bakiye, mesgul
  );
endinterface

// File: rtl/borsa_emir_sirala.sv
// Order scheduler: divides the balance by three quote prices on one shared
// restoring divider, picks the largest share count and debits the balance.
//
//   state       | meaning
//   BOSTA       | idle; balance load or bundle accept
//   BOL         | one load cycle, then BOLME_BIT iterations per quote
//   KARSILASTIR | pick winner, latch decision and post-trade balance
//   KARAR       | decision presented until karar_hazir
module borsa_emir_sirala #(
  parameter logic [63:0] ESIK      = 64'd1000,
  parameter int          BOLME_BIT = 64
) (
  input logic clk,
  input logic rst_n,
  borsa_emir_sirala_if.slave bus
);

  localparam int SW = $clog2(BOLME_BIT + 1);

  typedef enum logic [1:0] {BOSTA, BOL, KARSILASTIR, KARAR} durum_t;

  durum_t durum, durum_sonraki;

  logic [2:0][9:0]           no_r;
  logic [2:0][31:0]          deger_r;
  logic [2:0][BOLME_BIT-1:0] q_r;
  logic [2:0][BOLME_BIT-1:0] r_r;
  logic [BOLME_BIT-1:0]      bolunen;
  logic [BOLME_BIT-1:0]      bol_kalan;
  logic [BOLME_BIT-1:0]      bol_bolum;
  logic [SW-1:0]             sayac;
  logic [1:0]                k;
  logic                      ilk;
  logic [BOLME_BIT-1:0]      bakiye_r;
  logic [BOLME_BIT-1:0]      kalan;
  logic [1:0]                karar_r;
  logic [9:0]                karar_no_r;
  logic [BOLME_BIT-1:0]      kagit_r;

  logic [BOLME_BIT-1:0] bolen;
  logic [BOLME_BIT:0]   kaydir;
  logic [BOLME_BIT:0]   fark;
  logic                 sigar;
  logic [BOLME_BIT-1:0] yeni_kalan;
  logic [BOLME_BIT-1:0] yeni_bolum;
  logic [1:0]           kazanan;
  logic                 son_adim;
  logic                 kabul;

  assign kabul    = (durum == BOSTA) && !bus.bakiye_yukle && bus.teklif_gecerli;
  assign son_adim = !ilk && (sayac == SW'(1));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    bolen      = BOLME_BIT'(deger_r[k]);
    kaydir     = {bol_kalan, bol_bolum[BOLME_BIT-1]};
    fark       = kaydir - {1'b0, bolen};
    sigar      = !fark[BOLME_BIT];
    yeni_kalan = sigar ? fark[BOLME_BIT-1:0] : kaydir[BOLME_BIT-1:0];
    yeni_bolum = {bol_bolum[BOLME_BIT-2:0], sigar};
  end

  // Strict compares keep the lowest index on ties.
  always_comb begin
    kazanan = 2'd0;
    if (q_r[1] > q_r[0]) kazanan = 2'd1;
    if (q_r[2] > q_r[kazanan]) kazanan = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) durum <= BOSTA;
    else        durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA:       if (kabul) durum_sonraki = BOL;
      BOL:         if (son_adim && (k == 2'd2)) durum_sonraki = KARSILASTIR;
      KARSILASTIR: durum_sonraki = KARAR;
      KARAR:       if (bus.karar_hazir) durum_sonraki = BOSTA;
      default:     durum_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      no_r       <= '0;
      deger_r    <= '0;
      q_r        <= '0;
      r_r        <= '0;
      bolunen    <= '0;
      bol_kalan  <= '0;
      bol_bolum  <= '0;
      sayac      <= '0;
      k          <= '0;
      ilk        <= 1'b0;
      bakiye_r   <= '0;
      kalan      <= '0;
      karar_r    <= '0;
      karar_no_r <= '0;
      kagit_r    <= '0;
    end else begin
      case (durum)
        BOSTA: begin
          if (bus.bakiye_yukle) begin
            bakiye_r <= bus.bakiye_giris;
          end else if (bus.teklif_gecerli) begin
            no_r    <= {bus.hisse_numarasi3, bus.hisse_numarasi2, bus.hisse_numarasi1};
            deger_r <= {bus.hisse_deger3, bus.hisse_deger2, bus.hisse_deger1};
            bolunen <= bakiye_r;
            k       <= 2'd0;
            ilk     <= 1'b1;
            sayac   <= SW'(BOLME_BIT);
          end
        end
        BOL: begin
          if (ilk) begin
            bol_kalan <= '0;
            bol_bolum <= bolunen;
            ilk       <= 1'b0;
          end else if (son_adim) begin
            // A zero price would divide to all-ones; report no shares instead.
            q_r[k]    <= (deger_r[k] == 32'd0) ? '0 : yeni_bolum;
            r_r[k]    <= (deger_r[k] == 32'd0) ? bolunen : yeni_kalan;
            k         <= k + 2'd1;
            sayac     <= SW'(BOLME_BIT);
            bol_kalan <= '0;
            bol_bolum <= bolunen;
          end else begin
            bol_kalan <= yeni_kalan;
            bol_bolum <= yeni_bolum;
            sayac     <= sayac - SW'(1);
          end
        end
        KARSILASTIR: begin
          if (q_r[kazanan] > ESIK) begin
            karar_r    <= kazanan + 2'd1;
            karar_no_r <= no_r[kazanan];
            kagit_r    <= q_r[kazanan];
            kalan      <= r_r[kazanan];
          end else begin
            karar_r    <= 2'd0;
            karar_no_r <= '0;
            kagit_r    <= '0;
            kalan      <= bakiye_r;
          end
        end
        KARAR: begin
          if (bus.karar_hazir) bakiye_r <= kalan;
        end
        default: ;
      endcase
    end
  end

  assign bus.teklif_hazir  = (durum == BOSTA) && !bus.bakiye_yukle;
  assign bus.karar_gecerli = (durum == KARAR);
  assign bus.karar         = karar_r;
  assign bus.karar_no      = karar_no_r;
  assign bus.kagit_sayisi  = kagit_r;
  assign bus.bakiye        = bakiye_r;
  assign bus.mesgul        = (durum != BOSTA);

endmodule

// File: tb/tb_borsa_emir_sirala.sv
// Directed bench for borsa_emir_sirala: vector table of bundles with
// hand-computed decisions, plus reset, load-priority and hold sequences.
module tb_borsa_emir_sirala;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  borsa_emir_sirala_if bus();

  borsa_emir_sirala dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] bal;
    logic [9:0]  n1;
    logic [31:0] p1;
    logic [9:0]  n2;
    logic [31:0] p2;
    logic [9:0]  n3;
    logic [31:0] p3;
    bit          yukle_bol;
    logic [1:0]  k;
    logic [9:0]  no;
    logic [63:0] kagit;
    logic [63:0] son_bal;
  } vec_t;

  vec_t vt[7];
  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string ad, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", ad, got, want);
    end
  endtask

  task automatic load(input logic [63:0] b);
    bus.bakiye_yukle = 1'b1;
    bus.bakiye_giris = b;
    #1;
    chk("hazir_while_load", 64'(bus.teklif_hazir), 64'd0);
    step();
    bus.bakiye_yukle = 1'b0;
    chk("bakiye_load", bus.bakiye, b);
  endtask

  task automatic run_bundle(input vec_t v, output int lat);
    int n;
    bus.hisse_numarasi1 = v.n1;
    bus.hisse_deger1    = v.p1;
    bus.hisse_numarasi2 = v.n2;
    bus.hisse_deger2    = v.p2;
    bus.hisse_numarasi3 = v.n3;
    bus.hisse_deger3    = v.p3;
    bus.teklif_gecerli  = 1'b1;
    step();
    bus.teklif_gecerli = 1'b0;
    chk("mesgul_bol", 64'(bus.mesgul), 64'd1);
    chk("hazir_bol", 64'(bus.teklif_hazir), 64'd0);
    n = 0;
    while (!bus.karar_gecerli && n < 400) begin
      if (v.yukle_bol && n == 10) begin
        bus.bakiye_yukle = 1'b1;
        bus.bakiye_giris = 64'd12345;
      end else begin
        bus.bakiye_yukle = 1'b0;
      end
      step();
      n++;
    end
    bus.bakiye_yukle = 1'b0;
    lat = n;
  endtask

  initial begin
    int lat;
    bit gordu;

    vt[0] = '{64'd1000000, 10'd5, 32'd100, 10'd7, 32'd250, 10'd9, 32'd400, 1'b0, 2'd1, 10'd5, 64'd10000, 64'd0};
    vt[1] = '{64'd100030, 10'd1, 32'd200, 10'd2, 32'd50, 10'd3, 32'd50, 1'b0, 2'd2, 10'd2, 64'd2000, 64'd30};
    vt[2] = '{64'd50000, 10'd4, 32'd100, 10'd5, 32'd100, 10'd6, 32'd100, 1'b0, 2'd0, 10'd0, 64'd0, 64'd50000};
    vt[3] = '{64'd80000, 10'd10, 32'd0, 10'd11, 32'd0, 10'd12, 32'd40, 1'b1, 2'd3, 10'd12, 64'd2000, 64'd0};
    vt[4] = '{64'd7007, 10'd21, 32'd7, 10'd22, 32'd7, 10'd23, 32'd8, 1'b0, 2'd1, 10'd21, 64'd1001, 64'd0};
    vt[5] = '{64'd3002, 10'd31, 32'd3, 10'd32, 32'd3, 10'd33, 32'd3, 1'b0, 2'd0, 10'd0, 64'd0, 64'd3002};
    vt[6] = '{64'd1099511627776, 10'd100, 32'hFFFF_FFFF, 10'd200, 32'd3, 10'd300, 32'd7, 1'b0,
              2'd2, 10'd200, 64'd366503875925, 64'd1};

    bus.bakiye_yukle    = 1'b0;
    bus.bakiye_giris    = '0;
    bus.teklif_gecerli  = 1'b0;
    bus.karar_hazir     = 1'b0;
    bus.hisse_numarasi1 = '0;
    bus.hisse_deger1    = '0;
    bus.hisse_numarasi2 = '0;
    bus.hisse_deger2    = '0;
    bus.hisse_numarasi3 = '0;
    bus.hisse_deger3    = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step();

    // Asynchronous reset between clock edges clears a loaded balance at once.
    load(64'd777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_bakiye", bus.bakiye, 64'd0);
    chk("rst_mesgul", 64'(bus.mesgul), 64'd0);
    chk("rst_hazir", 64'(bus.teklif_hazir), 64'd1);
    chk("rst_gecerli", 64'(bus.karar_gecerli), 64'd0);
    chk("rst_karar", {52'd0, bus.karar, bus.karar_no}, 64'd0);
    chk("rst_kagit", bus.kagit_sayisi, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Load wins over a simultaneous bundle.
    bus.bakiye_yukle   = 1'b1;
    bus.bakiye_giris   = 64'd500;
    bus.teklif_gecerli = 1'b1;
    step();
    bus.bakiye_yukle   = 1'b0;
    bus.teklif_gecerli = 1'b0;
    chk("prio_mesgul", 64'(bus.mesgul), 64'd0);
    chk("prio_bakiye", bus.bakiye, 64'd500);

    for (int i = 0; i < 7; i++) begin
      load(vt[i].bal);
      run_bundle(vt[i], lat);
      chk($sformatf("lat_%0d", i), 64'(lat), 64'd194);
      chk($sformatf("karar_%0d", i), 64'(bus.karar), 64'(vt[i].k));
      chk($sformatf("no_%0d", i), 64'(bus.karar_no), 64'(vt[i].no));
      chk($sformatf("kagit_%0d", i), bus.kagit_sayisi, vt[i].kagit);
      bus.karar_hazir = 1'b1;
      step();
      bus.karar_hazir = 1'b0;
      chk($sformatf("gecerli_dus_%0d", i), 64'(bus.karar_gecerli), 64'd0);
      chk($sformatf("bakiye_son_%0d", i), bus.bakiye, vt[i].son_bal);
      chk($sformatf("hazir_sonra_%0d", i), 64'(bus.teklif_hazir), 64'd1);
      chk($sformatf("no_tut_%0d", i), 64'(bus.karar_no), 64'(vt[i].no));
    end

    // Decision held while downstream stalls.
    load(64'd1000000);
    run_bundle(vt[0], lat);
    chk("hold_lat", 64'(lat), 64'd194);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold", {60'd0, bus.karar_gecerli, bus.teklif_hazir,
                   bus.karar_no == 10'd5, bus.kagit_sayisi == 64'd10000}, 64'hB);
    end
    bus.karar_hazir = 1'b1;
    step();
    bus.karar_hazir = 1'b0;
    chk("hold_bakiye", bus.bakiye, 64'd0);

    // Reset in the middle of a division drops the bundle.
    load(64'd1000000);
    bus.teklif_gecerli = 1'b1;
    step();
    bus.teklif_gecerli = 1'b0;
    for (int c = 0; c < 50; c++) step();
    chk("mid_mesgul", 64'(bus.mesgul), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bakiye", bus.bakiye, 64'd0);
    chk("mid_rst_mesgul", 64'(bus.mesgul), 64'd0);
    chk("mid_rst_hazir", 64'(bus.teklif_hazir), 64'd1);
    chk("mid_rst_karar", {52'd0, bus.karar, bus.karar_no}, 64'd0);
    step();
    rst_n = 1'b1;
    gordu = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bus.karar_gecerli) gordu = 1'b1;
    end
    chk("mid_no_decision", 64'(gordu), 64'd0);
    chk("mid_bakiye_end", bus.bakiye, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/borsa_emir_sirala.md
Name: borsa_emir_sirala

Overview:
- Sequential order scheduler for the stock-decision datapath.
- Accepts a three-quote bundle (stock number and price) with a valid/ready handshake.
- Computes affordable share counts against an internal balance register, using one shared restoring divider time-multiplexed across the three quotes.
- Selects the best stock, presents the decision on a valid/ready output, and on acceptance debits the balance by the spent amount.

Parameters:
ESIK, 1000, minimum share count; a buy is issued only if the winning quotient is strictly greater than ESIK
BOLME_BIT, 64, dividend/quotient width; one divider iteration per cycle

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
bakiye_yukle  input  1  load balance strobe
bakiye_giris  input  64  balance value to load
teklif_gecerli  input  1  quote bundle valid
teklif_hazir  output  1  quote bundle ready
hisse_numarasi1  input  10  stock 1 number
hisse_deger1  input  32  stock 1 price
hisse_numarasi2  input  10  stock 2 number
hisse_deger2  input  32  stock 2 price
hisse_numarasi3  input  10  stock 3 number
hisse_deger3  input  32  stock 3 price
karar_gecerli  output  1  decision valid
karar_hazir  input  1  decision consumed by downstream
karar_no  output  10  selected stock number, 0 = none
karar  output  2  00 pass; 01/10/11 = buy stock 1/2/3
kagit_sayisi  output  64  shares to buy
bakiye  output  64  current balance register
mesgul  output  1  high in every state except BOSTA

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to BOSTA; divider, index and captured quotes are cleared.
  - Outputs: karar_gecerli=0, karar_no=0, karar=00, kagit_sayisi=0, bakiye=0, mesgul=0.
  - A reset mid-operation drops the pending bundle or decision with no balance change.
- teklif_hazir = (state==BOSTA) && !bakiye_yukle.
- BOSTA:
  - bakiye_yukle=1: bakiye <= bakiye_giris. Load has priority; no bundle is accepted in that cycle.
  - bakiye_yukle in any other state is ignored.
  - teklif_gecerli && teklif_hazir at edge T: capture all six quote inputs and the current bakiye as the dividend; go to BOL with index k=0.
- BOL:
  - Restoring division of the dividend by zero-extended deger[k], BOLME_BIT cycles per quote.
  - Store quotient q[k] and remainder r[k], then k++. After k=2 completes, go to KARSILASTIR.
  - deger[k]==0: q[k]=0, r[k]=dividend. Still consumes BOLME_BIT cycles so latency stays fixed.
- KARSILASTIR (1 cycle):
  - Winner is the maximum q; ties go to the lowest index.
  - If q_win > ESIK: karar = 2'd(win+1), karar_no = hisse_numarasi[win], kagit_sayisi = q_win, kalan = r_win.
  - Else: karar=00, karar_no=0, kagit_sayisi=0, kalan = bakiye.
  - Go to KARAR with karar_gecerli=1.
- Latency: karar_gecerli rises at edge T+3*BOLME_BIT+2, i.e. T+194 with defaults.
- KARAR:
  - Outputs are held stable while karar_gecerli && !karar_hazir.
  - On karar_hazir=1 at an edge: bakiye <= kalan (equals bakiye - kagit_sayisi*deger_win); karar_gecerli <= 0; go to BOSTA.
  - karar_no, karar and kagit_sayisi keep their last values after the handshake until the next KARSILASTIR.
- All arithmetic is unsigned. Quotient fits in 64 bits, so there is no overflow; the remainder is always less than the price, so the balance never underflows.
- Balance is only modified by bakiye_yukle in BOSTA or by a decision handshake; a pass decision rewrites the same value.
- Back-to-back operation: the first bundle is accepted in the cycle after the decision handshake at the earliest.

Test Plan:
1. Reset asserted mid-cycle, asynchronously -> all outputs zero immediately, teklif_hazir=1, mesgul=0.
2. Load bakiye=1_000_000; bundle (5,100),(7,250),(9,400) -> after 194 cycles karar_gecerli=1, karar=01, karar_no=5, kagit_sayisi=10000; after handshake bakiye=0.
3. bakiye=100_030; bundle (1,200),(2,50),(3,50) -> q=500,2000,2000, tie -> karar=10, karar_no=2, kagit_sayisi=2000; after handshake bakiye=30.
4. bakiye=50_000; all prices 100 -> q=500 each, not > ESIK -> karar=00, karar_no=0, kagit_sayisi=0; after handshake bakiye=50_000.
5. bakiye=80_000; prices 0,0,40 with number3=12 -> karar=11, karar_no=12, kagit_sayisi=2000, latency still 194; bakiye_yukle pulsed in BOL is ignored.
6. Hold karar_hazir=0 for 10 cycles -> outputs stable and teklif_hazir=0. Then drop rst_n during BOL of a second bundle -> no decision issued, bakiye=0.
